// File: rtl/mem_bank.sv
// Single-port word memory with byte-enable writes and a handshaked, optionally wait-stated read path.
// Define MEM_PARITY_EN to add per-byte even parity, the err_inj_i port and parity checking on reads.
module mem_bank #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   be_i,
`ifdef MEM_PARITY_EN
    input  logic                  err_inj_i,
`endif
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_W-1:0]     data_o,
    output logic                  err_o
);

    localparam int NB     = DATA_W / 8;
    localparam int LSB    = (NB > 1) ? $clog2(NB) : 0;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIDX_W = ADDR_W - LSB;

    // Handshake: a request transfers on any rising edge with req_i=1 and gnt_o=1; the master
    // holds req_i and its qualifiers until granted, and each transfer yields one rvalid_o pulse.
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [AW-1:0]     lat_idx;
    logic              lat_oor;
    logic              accept, rd_load, wr_resp, lat_load;
    logic [WIDX_W-1:0] word_idx;
    logic [AW-1:0]     cur_idx, rd_idx;
    logic              cur_in, rd_oor, rd_perr;
    logic [DATA_W-1:0] rd_word;
    logic              unused_addr;

`ifdef MEM_PARITY_EN
    logic [DATA_W-1:0] mem     [DEPTH] = '{default: '0};
    logic [NB-1:0]     par_mem [DEPTH] = '{default: '0};
`else
    logic [DATA_W-1:0] mem [DEPTH];
`endif

    assign word_idx    = addr_i[ADDR_W-1:LSB];
    assign cur_idx     = word_idx[AW-1:0];
    assign cur_in      = 64'(word_idx) < 64'(DEPTH);
    assign unused_addr = ^addr_i;

    assign gnt_o    = (state != WAIT);
    assign rvalid_o = (state == RESP);
    assign accept   = req_i && gnt_o;

    // A wait-stated read uses the latched address; everything else reads the live address.
    assign rd_idx  = (state == WAIT) ? lat_idx : cur_idx;
    assign rd_oor  = (state == WAIT) ? lat_oor : !cur_in;
    assign rd_word = rd_oor ? '0 : mem[rd_idx];

`ifdef MEM_PARITY_EN
    always_comb begin
        rd_perr = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if ((^rd_word[8*b +: 8]) != par_mem[rd_idx][b]) rd_perr = 1'b1;
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_load   = 1'b0;
        wr_resp   = 1'b0;
        lat_load  = 1'b0;
        case (state)
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    cnt_nxt   = 4'd0;
                    rd_load   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (we_i) begin
                        state_nxt = RESP;
                        wr_resp   = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        rd_load   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES);
                        lat_load  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            data_o  <= '0;
            err_o   <= 1'b0;
            lat_idx <= '0;
            lat_oor <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (lat_load) begin
                lat_idx <= cur_idx;
                lat_oor <= !cur_in;
            end
            if (rd_load) begin
                data_o <= rd_word;
                err_o  <= rd_oor | rd_perr;
            end else if (wr_resp) begin
                err_o <= !cur_in;
            end
        end
    end

    // Writes commit on the accept edge, so a later read always sees them; reset blocks the commit.
    always_ff @(posedge clk) begin
        if (rst && accept && we_i && cur_in) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[cur_idx][8*b +: 8] <= data_i[8*b +: 8];
`ifdef MEM_PARITY_EN
                    par_mem[cur_idx][b] <= (^data_i[8*b +: 8]) ^ err_inj_i;
`endif
                end
            end
        end
    end

endmodule
